// File: rtl/snake_logic.sv
`timescale 1ns/1ps
// snake_logic: tick-driven snake move / self-collision / food datapath; LOGIC_DONE lands L+2 cycles after a tick.
// prng_req is held until prng_ack; ticks outside IDLE are dropped. Define SNAKE_WALL_KILL_EN to make edge wraps fatal.
module snake_logic #(
  parameter int MAX_LEN   = 16,
  parameter int FOOD_INIT = 29
) (
  input  logic        clka,
  input  logic        restart,
  input  logic [1:0]  to_logic,
  input  logic [1:0]  direction_state,
  output logic [2:0]  from_logic,
  output logic [63:0] led_array,
  output logic        prng_req,
  input  logic        prng_ack,
  input  logic [5:0]  prng_value,
  output logic [5:0]  head_pos,
  output logic [4:0]  snake_len
);

  localparam int            PW        = $clog2(MAX_LEN);
  localparam logic [PW-1:0] LAST_PTR  = PW'(MAX_LEN - 1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [4:0]    MAX_LEN_L = 5'(MAX_LEN);
  localparam logic [5:0]    FOOD_RST  = 6'(FOOD_INIT);
  localparam logic [5:0]    TAIL_RST  = 6'd25;
  localparam logic [5:0]    HEAD_RST  = 6'd26;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_SCAN,
    S_COMMIT,
    S_FOOD_REQ,
    S_FOOD_PLACE,
    S_PDONE
  } state_t;

  state_t        state_q;
  logic [5:0]    body_q [MAX_LEN];
  logic [63:0]   body_map_q;
  logic [PW-1:0] head_ptr_q;
  logic [PW-1:0] tail_ptr_q;
  logic [PW-1:0] scan_ptr_q;
  logic [5:0]    head_q;
  logic [5:0]    food_q;
  logic [5:0]    cand_q;
  logic [5:0]    new_head_q;
  logic [4:0]    len_q;
  logic [4:0]    scan_idx_q;
  logic [1:0]    dir_q;
  logic          eat_q;
  logic          grow_q;
  logic          blink_q;
  logic          logic_done_q;
  logic          prng_done_q;
  logic          game_end_q;
  logic          prng_req_q;

  logic [2:0]    row_c;
  logic [2:0]    col_c;
  logic [5:0]    new_head_d;
  logic [5:0]    tail_cell_d;
  logic [63:0]   body_map_d;
  logic [PW-1:0] head_ptr_d;
  logic          hit_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_ONE;
  endfunction

  assign row_c = head_q[5:3];
  assign col_c = head_q[2:0];

  always_comb begin
    new_head_d = head_q;
    case (dir_q)
      DIR_UP:    new_head_d = {row_c - 3'd1, col_c};
      DIR_DOWN:  new_head_d = {row_c + 3'd1, col_c};
      DIR_LEFT:  new_head_d = {row_c, col_c - 3'd1};
      DIR_RIGHT: new_head_d = {row_c, col_c + 3'd1};
      default:   new_head_d = head_q;
    endcase
  end

`ifdef SNAKE_WALL_KILL_EN
  logic wall_d;

  always_comb begin
    wall_d = 1'b0;
    case (dir_q)
      DIR_UP:    wall_d = (row_c == 3'd0);
      DIR_DOWN:  wall_d = (row_c == 3'd7);
      DIR_LEFT:  wall_d = (col_c == 3'd0);
      DIR_RIGHT: wall_d = (col_c == 3'd7);
      default:   wall_d = 1'b0;
    endcase
  end
`endif

  // Entry 0 of the scan is the tail; it vacates this move unless the snake grows.
  assign hit_d       = (body_q[scan_ptr_q] == new_head_q) && !((scan_idx_q == 5'd0) && !grow_q);
  assign tail_cell_d = body_q[tail_ptr_q];
  assign head_ptr_d  = ptr_inc(head_ptr_q);
  // Set after clear so a head moving into the just-vacated tail cell stays lit.
  assign body_map_d  = (grow_q ? body_map_q : (body_map_q & ~(64'd1 << tail_cell_d)))
                     | (64'd1 << new_head_q);

  always_ff @(posedge clka) begin
    if (restart) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        body_q[i] <= '0;
      end
      body_q[0]    <= TAIL_RST;
      body_q[1]    <= HEAD_RST;
      body_map_q   <= (64'd1 << TAIL_RST) | (64'd1 << HEAD_RST);
      head_ptr_q   <= PTR_ONE;
      tail_ptr_q   <= '0;
      scan_ptr_q   <= '0;
      head_q       <= HEAD_RST;
      food_q       <= FOOD_RST;
      cand_q       <= '0;
      new_head_q   <= '0;
      len_q        <= 5'd2;
      scan_idx_q   <= '0;
      dir_q        <= DIR_UP;
      eat_q        <= 1'b0;
      grow_q       <= 1'b0;
      blink_q      <= 1'b0;
      logic_done_q <= 1'b0;
      prng_done_q  <= 1'b0;
      game_end_q   <= 1'b0;
      prng_req_q   <= 1'b0;
    end else begin
      logic_done_q <= 1'b0;
      prng_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (to_logic[0]) begin
            if (to_logic[1] || game_end_q) begin
              blink_q      <= ~blink_q;
              logic_done_q <= 1'b1;
              state_q      <= S_PDONE;
            end else begin
              dir_q   <= direction_state;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          new_head_q <= new_head_d;
          eat_q      <= (new_head_d == food_q);
          grow_q     <= (new_head_d == food_q) && (len_q < MAX_LEN_L);
          scan_idx_q <= '0;
          scan_ptr_q <= tail_ptr_q;
`ifdef SNAKE_WALL_KILL_EN
          if (wall_d) begin
            game_end_q   <= 1'b1;
            logic_done_q <= 1'b1;
            state_q      <= S_PDONE;
          end else begin
            state_q <= S_SCAN;
          end
`else
          state_q    <= S_SCAN;
`endif
        end
        S_SCAN: begin
          if (hit_d) begin
            game_end_q   <= 1'b1;
            logic_done_q <= 1'b1;
            state_q      <= S_PDONE;
          end else if (scan_idx_q == len_q - 5'd1) begin
            state_q <= S_COMMIT;
          end else begin
            scan_idx_q <= scan_idx_q + 5'd1;
            scan_ptr_q <= ptr_inc(scan_ptr_q);
          end
        end
        S_COMMIT: begin
          body_q[head_ptr_d] <= new_head_q;
          head_ptr_q         <= head_ptr_d;
          head_q             <= new_head_q;
          body_map_q         <= body_map_d;
          blink_q            <= 1'b0;
          logic_done_q       <= 1'b1;
          if (grow_q) begin
            len_q <= len_q + 5'd1;
          end else begin
            tail_ptr_q <= ptr_inc(tail_ptr_q);
          end
          if (eat_q) begin
            prng_req_q <= 1'b1;
            state_q    <= S_FOOD_REQ;
          end else begin
            state_q <= S_PDONE;
          end
        end
        S_FOOD_REQ: begin
          if (prng_ack) begin
            cand_q     <= prng_value;
            prng_req_q <= 1'b0;
            state_q    <= S_FOOD_PLACE;
          end
        end
        S_FOOD_PLACE: begin
          // Linear probe terminates: at most MAX_LEN cells are occupied.
          if (body_map_q[cand_q]) begin
            cand_q <= cand_q + 6'd1;
          end else begin
            food_q  <= cand_q;
            state_q <= S_PDONE;
          end
        end
        S_PDONE: begin
          prng_done_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    led_array = body_map_q | (64'd1 << food_q);
    if (blink_q) begin
      led_array[head_q] = 1'b0;
    end
  end

  assign from_logic = {game_end_q, prng_done_q, logic_done_q};
  assign prng_req   = prng_req_q;
  assign head_pos   = head_q;
  assign snake_len  = len_q;

endmodule

// File: tb/tb_snake_logic.sv
`timescale 1ns/1ps
// Directed bench for snake_logic: moves, eating with probe, wrap/wall, self-collision, blink, mid-update restart.
module tb_snake_logic;

  logic        clka = 1'b0;
  logic        restart = 1'b1;
  logic [1:0]  to_logic = 2'd0;
  logic [1:0]  direction_state = 2'd0;
  logic [2:0]  from_logic;
  logic [63:0] led_array;
  logic        prng_req;
  logic        prng_ack = 1'b0;
  logic [5:0]  prng_value = 6'd0;
  logic [5:0]  head_pos;
  logic [4:0]  snake_len;

  int vec_cnt = 0;
  int miss_cnt = 0;
  int ld, pd, rq;

  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;
  localparam logic [63:0] ONE = 64'd1;
  localparam logic [63:0] LED_RST = (ONE << 25) | (ONE << 26) | (ONE << 29);

  snake_logic dut (
    .clka            (clka),
    .restart         (restart),
    .to_logic        (to_logic),
    .direction_state (direction_state),
    .from_logic      (from_logic),
    .led_array       (led_array),
    .prng_req        (prng_req),
    .prng_ack        (prng_ack),
    .prng_value      (prng_value),
    .head_pos        (head_pos),
    .snake_len       (snake_len)
  );

  always #5 clka = ~clka;

  task automatic do_reset();
    restart  = 1'b1;
    to_logic = 2'd0;
    prng_ack = 1'b0;
    repeat (2) @(posedge clka);
    #1 restart = 1'b0;
  endtask

  // Issue one tick; cycle n is sampled #1 after the n-th edge following the sampling edge (n=0).
  // Answers a food request with ack_val; returns -1 for any event that never showed up.
  task automatic run_tick(input logic [1:0] tl, input logic [1:0] dir, input logic [5:0] ack_val,
                          output int ld_cyc, output int pd_cyc, output int req_cyc);
    @(negedge clka);
    to_logic        = tl;
    direction_state = dir;
    @(posedge clka);
    #1 to_logic = 2'd0;
    ld_cyc = -1; pd_cyc = -1; req_cyc = -1;
    for (int n = 0; n < 60; n++) begin
      if (n > 0) begin
        @(posedge clka);
        #1;
      end
      prng_ack = 1'b0;
      if (from_logic[0] && ld_cyc < 0) ld_cyc = n;
      if (from_logic[1]) begin
        pd_cyc = n;
        break;
      end
      if (prng_req && req_cyc < 0) begin
        req_cyc    = n;
        prng_ack   = 1'b1;
        prng_value = ack_val;
      end
    end
    prng_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++; if (head_pos !== 6'd26) begin miss_cnt++; $display("FAIL reset_head: got %0d want 26", head_pos); end
    vec_cnt++; if (snake_len !== 5'd2) begin miss_cnt++; $display("FAIL reset_len: got %0d want 2", snake_len); end
    vec_cnt++; if (led_array !== LED_RST) begin miss_cnt++; $display("FAIL reset_led: got %h want %h", led_array, LED_RST); end
    vec_cnt++; if (from_logic !== 3'b000) begin miss_cnt++; $display("FAIL reset_from_logic: got %b want 000", from_logic); end
    vec_cnt++; if (prng_req !== 1'b0) begin miss_cnt++; $display("FAIL reset_prng_req: got %b want 0", prng_req); end
  endtask

  task automatic test_move_right();
    logic [63:0] exp_led;
    exp_led = (ONE << 26) | (ONE << 27) | (ONE << 29);
    do_reset();
    run_tick(2'b01, RIGHT, 6'd0, ld, pd, rq);
    vec_cnt++; if (ld !== 4) begin miss_cnt++; $display("FAIL move_ld_cycle: got %0d want 4", ld); end
    vec_cnt++; if (pd !== 5) begin miss_cnt++; $display("FAIL move_pd_cycle: got %0d want 5", pd); end
    vec_cnt++; if (rq !== -1) begin miss_cnt++; $display("FAIL move_prng_req: got cycle %0d want never", rq); end
    vec_cnt++; if (head_pos !== 6'd27) begin miss_cnt++; $display("FAIL move_head: got %0d want 27", head_pos); end
    vec_cnt++; if (led_array !== exp_led) begin miss_cnt++; $display("FAIL move_led: got %h want %h", led_array, exp_led); end
  endtask

  task automatic test_eat_probe();
    logic [63:0] exp_led;
    exp_led = (ONE << 27) | (ONE << 28) | (ONE << 29) | (ONE << 30);
    do_reset();
    run_tick(2'b01, RIGHT, 6'd0, ld, pd, rq);
    run_tick(2'b01, RIGHT, 6'd0, ld, pd, rq);
    run_tick(2'b01, RIGHT, 6'd27, ld, pd, rq);
    vec_cnt++; if (ld !== 4) begin miss_cnt++; $display("FAIL eat_ld_cycle: got %0d want 4", ld); end
    vec_cnt++; if (rq !== 4) begin miss_cnt++; $display("FAIL eat_req_cycle: got %0d want 4", rq); end
    // ack at 5, probe 27->28->29->30 over edges 6..9, PRNG_DONE at 10
    vec_cnt++; if (pd !== 10) begin miss_cnt++; $display("FAIL eat_pd_cycle: got %0d want 10", pd); end
    vec_cnt++; if (snake_len !== 5'd3) begin miss_cnt++; $display("FAIL eat_len: got %0d want 3", snake_len); end
    vec_cnt++; if (led_array !== exp_led) begin miss_cnt++; $display("FAIL eat_led: got %h want %h", led_array, exp_led); end
    vec_cnt++; if (prng_req !== 1'b0) begin miss_cnt++; $display("FAIL eat_req_drop: got %b want 0", prng_req); end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_led;
    do_reset();
    run_tick(2'b01, RIGHT, 6'd0, ld, pd, rq);
    run_tick(2'b01, RIGHT, 6'd0, ld, pd, rq);
    run_tick(2'b01, RIGHT, 6'd0, ld, pd, rq);
    vec_cnt++; if (pd !== 7) begin miss_cnt++; $display("FAIL wrap_food_pd_cycle: got %0d want 7", pd); end
    run_tick(2'b01, RIGHT, 6'd0, ld, pd, rq);
    run_tick(2'b01, RIGHT, 6'd0, ld, pd, rq);
    vec_cnt++; if (head_pos !== 6'd31) begin miss_cnt++; $display("FAIL wrap_pre_head: got %0d want 31", head_pos); end
    run_tick(2'b01, RIGHT, 6'd0, ld, pd, rq);
`ifdef SNAKE_WALL_KILL_EN
    exp_led = (ONE << 29) | (ONE << 30) | (ONE << 31) | ONE;
    vec_cnt++; if (ld !== 1) begin miss_cnt++; $display("FAIL wall_ld_cycle: got %0d want 1", ld); end
    vec_cnt++; if (pd !== 2) begin miss_cnt++; $display("FAIL wall_pd_cycle: got %0d want 2", pd); end
    vec_cnt++; if (head_pos !== 6'd31) begin miss_cnt++; $display("FAIL wall_head: got %0d want 31", head_pos); end
    vec_cnt++; if (from_logic[2] !== 1'b1) begin miss_cnt++; $display("FAIL wall_game_end: got %b want 1", from_logic[2]); end
`else
    exp_led = (ONE << 30) | (ONE << 31) | (ONE << 24) | ONE;
    vec_cnt++; if (ld !== 5) begin miss_cnt++; $display("FAIL wrap_ld_cycle: got %0d want 5", ld); end
    vec_cnt++; if (pd !== 6) begin miss_cnt++; $display("FAIL wrap_pd_cycle: got %0d want 6", pd); end
    vec_cnt++; if (head_pos !== 6'd24) begin miss_cnt++; $display("FAIL wrap_head: got %0d want 24", head_pos); end
    vec_cnt++; if (from_logic[2] !== 1'b0) begin miss_cnt++; $display("FAIL wrap_game_end: got %b want 0", from_logic[2]); end
`endif
    vec_cnt++; if (led_array !== exp_led) begin miss_cnt++; $display("FAIL wrap_led: got %h want %h", led_array, exp_led); end
  endtask

  task automatic test_self_collision();
    logic [63:0] exp_led;
    do_reset();
    run_tick(2'b01, RIGHT, 6'd0,  ld, pd, rq);
    run_tick(2'b01, RIGHT, 6'd0,  ld, pd, rq);
    run_tick(2'b01, RIGHT, 6'd37, ld, pd, rq);
    run_tick(2'b01, DOWN,  6'd36, ld, pd, rq);
    run_tick(2'b01, LEFT,  6'd0,  ld, pd, rq);
    vec_cnt++; if (snake_len !== 5'd5) begin miss_cnt++; $display("FAIL loop_len: got %0d want 5", snake_len); end
    run_tick(2'b01, UP, 6'd0, ld, pd, rq);
    exp_led = (ONE << 27) | (ONE << 28) | (ONE << 29) | (ONE << 37) | (ONE << 36) | ONE;
    vec_cnt++; if (ld !== 3) begin miss_cnt++; $display("FAIL hit_ld_cycle: got %0d want 3", ld); end
    vec_cnt++; if (pd !== 4) begin miss_cnt++; $display("FAIL hit_pd_cycle: got %0d want 4", pd); end
    vec_cnt++; if (from_logic[2] !== 1'b1) begin miss_cnt++; $display("FAIL hit_game_end: got %b want 1", from_logic[2]); end
    vec_cnt++; if (head_pos !== 6'd36) begin miss_cnt++; $display("FAIL hit_head: got %0d want 36", head_pos); end
    vec_cnt++; if (led_array !== exp_led) begin miss_cnt++; $display("FAIL hit_led: got %h want %h", led_array, exp_led); end
    run_tick(2'b01, UP, 6'd0, ld, pd, rq);
    exp_led = exp_led & ~(ONE << 36);
    vec_cnt++; if (ld !== 0 || pd !== 1) begin miss_cnt++; $display("FAIL end_tick_cycles: got ld %0d pd %0d want 0 1", ld, pd); end
    vec_cnt++; if (led_array !== exp_led) begin miss_cnt++; $display("FAIL end_tick_led: got %h want %h", led_array, exp_led); end
    vec_cnt++; if (from_logic[2] !== 1'b1 || snake_len !== 5'd5) begin miss_cnt++; $display("FAIL end_latched: got ge %b len %0d want 1 5", from_logic[2], snake_len); end
  endtask

  task automatic test_blink();
    logic [63:0] exp_led;
    exp_led = (ONE << 25) | (ONE << 29);
    do_reset();
    run_tick(2'b11, RIGHT, 6'd0, ld, pd, rq);
    vec_cnt++; if (ld !== 0 || pd !== 1) begin miss_cnt++; $display("FAIL blink_cycles: got ld %0d pd %0d want 0 1", ld, pd); end
    vec_cnt++; if (led_array !== exp_led) begin miss_cnt++; $display("FAIL blink_off_led: got %h want %h", led_array, exp_led); end
    vec_cnt++; if (head_pos !== 6'd26) begin miss_cnt++; $display("FAIL blink_head: got %0d want 26", head_pos); end
    run_tick(2'b11, RIGHT, 6'd0, ld, pd, rq);
    vec_cnt++; if (led_array !== LED_RST) begin miss_cnt++; $display("FAIL blink_on_led: got %h want %h", led_array, LED_RST); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clka);
    to_logic = 2'b01; direction_state = RIGHT;
    @(posedge clka);
    #1 to_logic = 2'b00;
    ld = -1; pd = -1;
    for (int n = 1; n < 30 && pd < 0; n++) begin
      if (n == 1) begin
        to_logic = 2'b01; direction_state = DOWN;
      end
      @(posedge clka);
      #1 to_logic = 2'b00;
      if (from_logic[0] && ld < 0) ld = n;
      if (from_logic[1]) pd = n;
    end
    vec_cnt++; if (ld !== 4 || pd !== 5) begin miss_cnt++; $display("FAIL b2b_cycles: got ld %0d pd %0d want 4 5", ld, pd); end
    vec_cnt++; if (head_pos !== 6'd27) begin miss_cnt++; $display("FAIL b2b_head: got %0d want 27", head_pos); end
  endtask

  task automatic test_restart_mid();
    int pulses;
    bit seen;
    // restart while in SCAN
    do_reset();
    @(negedge clka);
    to_logic = 2'b01; direction_state = RIGHT;
    @(posedge clka);
    #1 to_logic = 2'b00;
    @(posedge clka);
    #1 restart = 1'b1;
    @(posedge clka);
    #1;
    vec_cnt++; if (head_pos !== 6'd26 || snake_len !== 5'd2) begin miss_cnt++; $display("FAIL rst_scan_body: got head %0d len %0d want 26 2", head_pos, snake_len); end
    vec_cnt++; if (led_array !== LED_RST) begin miss_cnt++; $display("FAIL rst_scan_led: got %h want %h", led_array, LED_RST); end
    restart = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clka);
      #1 if (from_logic !== 3'b000 || prng_req !== 1'b0) pulses++;
    end
    vec_cnt++; if (pulses !== 0) begin miss_cnt++; $display("FAIL rst_scan_quiet: got %0d active cycles want 0", pulses); end
    // restart while in FOOD_REQ
    do_reset();
    run_tick(2'b01, RIGHT, 6'd0, ld, pd, rq);
    run_tick(2'b01, RIGHT, 6'd0, ld, pd, rq);
    @(negedge clka);
    to_logic = 2'b01; direction_state = RIGHT;
    @(posedge clka);
    #1 to_logic = 2'b00;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (prng_req) seen = 1'b1;
      else begin
        @(posedge clka);
        #1;
      end
    end
    vec_cnt++; if (seen !== 1'b1) begin miss_cnt++; $display("FAIL rst_req_seen: got %b want 1", seen); end
    restart = 1'b1;
    @(posedge clka);
    #1;
    vec_cnt++; if (prng_req !== 1'b0 || from_logic !== 3'b000) begin miss_cnt++; $display("FAIL rst_req_outputs: got req %b fl %b want 0 000", prng_req, from_logic); end
    vec_cnt++; if (snake_len !== 5'd2 || led_array !== LED_RST) begin miss_cnt++; $display("FAIL rst_req_board: got len %0d led %h want 2 %h", snake_len, led_array, LED_RST); end
    restart = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clka);
      #1 if (from_logic !== 3'b000 || prng_req !== 1'b0) pulses++;
    end
    vec_cnt++; if (pulses !== 0) begin miss_cnt++; $display("FAIL rst_req_quiet: got %0d active cycles want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_eat_probe();
    test_wrap();
    test_self_collision();
    test_blink();
    test_back_to_back();
    test_restart_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
